// File: rtl/pds_pkg.sv
// rtl/pds_pkg.sv - shared state type, encodings and round-robin pick for pattern_detect_scheduler
package pds_pkg;

  // State encodings, kept explicit so waveforms and debug taps stay stable
  localparam logic [1:0] PDS_ST_IDLE   = 2'd0;
  localparam logic [1:0] PDS_ST_CLEAR  = 2'd1;
  localparam logic [1:0] PDS_ST_SHIFT  = 2'd2;
  localparam logic [1:0] PDS_ST_REPORT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = PDS_ST_IDLE,
    CLEAR  = PDS_ST_CLEAR,
    SHIFT  = PDS_ST_SHIFT,
    REPORT = PDS_ST_REPORT
  } state_t;

  // The pick function works on a fixed-width request vector so that one
  // definition serves every NUM_REQ up to PDS_MAX_REQ.
  localparam int PDS_MAX_REQ = 32;
  localparam int PDS_IDX_W   = 5;

  // First set request found searching upward from ptr with wrap at num.
  // The loop runs from the far end down so the nearest candidate wins last.
  // Returns ptr when nothing is requested; callers qualify with |req.
  function automatic logic [PDS_IDX_W-1:0] rr_pick(
    input logic [PDS_MAX_REQ-1:0] req,
    input logic [PDS_IDX_W-1:0]   ptr,
    input logic [PDS_IDX_W:0]     num
  );
    logic [PDS_IDX_W-1:0] win;
    logic [PDS_IDX_W:0]   idx;
    logic [PDS_IDX_W:0]   off;
    win = ptr;
    for (int k = PDS_MAX_REQ - 1; k >= 0; k--) begin
      off = (PDS_IDX_W + 1)'(k);
      idx = {1'b0, ptr} + off;
      if (idx >= num) begin
        idx = idx - num;
      end
      if ((off < num) && req[idx[PDS_IDX_W-1:0]]) begin
        win = idx[PDS_IDX_W-1:0];
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner select with registered rotation pointer
module rr_arbiter
  import pds_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic               any,
  output logic [ID_W-1:0]    winner
);

  logic [ID_W-1:0]        rr_ptr;
  logic [PDS_MAX_REQ-1:0] req_ext;

  // Winner search starting at rr_ptr, wrapping at NUM_REQ
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    any                    = |req;
    winner = ID_W'(rr_pick(req_ext, PDS_IDX_W'(rr_ptr), (PDS_IDX_W + 1)'(NUM_REQ)));
  end

  // Pointer moves just past the requester that was granted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance && any) begin
      if (winner == ID_W'(NUM_REQ - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= winner + ID_W'(1);
      end
    end
  end

endmodule

// File: rtl/pattern_detect_scheduler.sv
// rtl/pattern_detect_scheduler.sv - time-shares one serial pattern detector among requesters (option: PDS_FIRST_HIT_EN)
module pattern_detect_scheduler
  import pds_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WORD_W  = 8,
  parameter  int CNT_W   = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
`ifdef PDS_FIRST_HIT_EN
  ,
  localparam int POS_W   = $clog2(WORD_W) + 1
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*WORD_W-1:0] word_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      det_reset,
  output logic                      det_x,
  input  logic                      det_y,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic [CNT_W-1:0]          hit_count
`ifdef PDS_FIRST_HIT_EN
  ,
  output logic [POS_W-1:0]          first_pos
`endif
);

  localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t               state;
  logic [WORD_W-1:0]    sreg;
  logic [BC_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]     hit_cnt;
  logic [ID_W-1:0]      cur_id;
`ifdef PDS_FIRST_HIT_EN
  logic [POS_W-1:0]     pos_r;
`endif

  logic                 arb_any;
  logic [ID_W-1:0]      winner;
  logic [WORD_W-1:0]    sel_word;
  logic [NUM_REQ-1:0]   gnt_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (state == IDLE),
    .any     (arb_any),
    .winner  (winner)
  );

  // Winner's word and one-hot grant, ready for capture at the grant edge
  always_comb begin
    sel_word = '0;
    gnt_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_word    = word_in[i*WORD_W +: WORD_W];
        gnt_next[i] = 1'b1;
      end
    end
  end

  // Detector is held clear during reset and for the one CLEAR cycle
  assign det_reset = reset | (state == CLEAR);

  // Service sequencer: arbitrate, clear detector, stream word MSB-first, report.
  // det_x is registered one step ahead, so sreg leads the bit on the wire by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= 1'b0;
      done_id   <= '0;
      hit_count <= '0;
      det_x     <= 1'b0;
      sreg      <= '0;
      bit_cnt   <= '0;
      hit_cnt   <= '0;
      cur_id    <= '0;
`ifdef PDS_FIRST_HIT_EN
      pos_r     <= POS_W'(WORD_W);
      first_pos <= POS_W'(WORD_W);
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt     <= gnt_next;
            sreg    <= sel_word;
            cur_id  <= winner;
            hit_cnt <= '0;
            bit_cnt <= '0;
`ifdef PDS_FIRST_HIT_EN
            pos_r   <= POS_W'(WORD_W);
`endif
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          bit_cnt <= '0;
          det_x   <= sreg[WORD_W-1];
          sreg    <= sreg << 1;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (det_y) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
`ifdef PDS_FIRST_HIT_EN
            if (pos_r == POS_W'(WORD_W)) begin
              pos_r <= POS_W'(bit_cnt);
            end
`endif
          end
          bit_cnt <= bit_cnt + BC_W'(1);
          sreg    <= sreg << 1;
          if (bit_cnt == BC_W'(WORD_W - 1)) begin
            det_x <= 1'b0;
            state <= REPORT;
          end else begin
            det_x <= sreg[WORD_W-1];
          end
        end
        REPORT: begin
          done      <= 1'b1;
          done_id   <= cur_id;
          hit_count <= hit_cnt;
`ifdef PDS_FIRST_HIT_EN
          first_pos <= pos_r;
`endif
          gnt       <= '0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_detect_scheduler.sv
// tb/tb_pattern_detect_scheduler.sv - randomized scoreboard bench for pattern_detect_scheduler
module tb_pattern_detect_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WORD_W  = 8;
  localparam int CNT_W   = 4;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*WORD_W-1:0] word_in = '0;
  logic [NUM_REQ-1:0]        gnt;
  logic                      det_reset;
  logic                      det_x;
  logic                      det_y;
  logic                      done;
  logic [ID_W-1:0]           done_id;
  logic [CNT_W-1:0]          hit_count;
`ifdef PDS_FIRST_HIT_EN
  logic [3:0]                first_pos;
`endif

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pattern_detect_scheduler #(
    .NUM_REQ (NUM_REQ),
    .WORD_W  (WORD_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .word_in   (word_in),
    .gnt       (gnt),
    .det_reset (det_reset),
    .det_x     (det_x),
    .det_y     (det_y),
    .done      (done),
    .done_id   (done_id),
    .hit_count (hit_count)
`ifdef PDS_FIRST_HIT_EN
    ,
    .first_pos (first_pos)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Attached detector: Mealy "010", non-overlapping, synchronous clear
  logic [1:0] dst;
  always @(posedge clk) begin
    if (det_reset) dst <= 2'd0;
    else begin
      case (dst)
        2'd0:    dst <= det_x ? 2'd0 : 2'd1;
        2'd1:    dst <= det_x ? 2'd2 : 2'd1;
        default: dst <= 2'd0;
      endcase
    end
  end
  assign det_y = (dst == 2'd2) && !det_x;

  // Reference: greedy leftmost non-overlapping scan for 0,1,0 over the streamed bits
  function automatic void scan(input logic [WORD_W-1:0] w, output int hits, output int first);
    int i;
    int b[WORD_W];
    for (int k = 0; k < WORD_W; k++) b[k] = int'(w[WORD_W-1-k]);
    hits = 0;
    first = WORD_W;
    i = 0;
    while (i + 2 < WORD_W) begin
      if (b[i] == 0 && b[i+1] == 1 && b[i+2] == 0) begin
        hits++;
        if (first == WORD_W) first = i + 2;
        i += 3;
      end else begin
        i++;
      end
    end
  endfunction

  typedef struct {
    int                id;
    logic [WORD_W-1:0] word;
    int                hits;
    int                first;
  } exp_t;

  exp_t expq[$];

  // Transaction model: one service occupies the grant edge plus ten more edges
  int   m_busy = 0;
  int   m_ptr  = 0;
  int   m_win;
  exp_t m_e;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0;
      m_ptr  = 0;
      expq.delete();
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (req != '0) begin
      m_win = -1;
      for (int k = 0; k < NUM_REQ; k++)
        if (m_win < 0 && req[(m_ptr + k) % NUM_REQ]) m_win = (m_ptr + k) % NUM_REQ;
      m_e.id   = m_win;
      m_e.word = word_in[m_win*WORD_W +: WORD_W];
      scan(m_e.word, m_e.hits, m_e.first);
      expq.push_back(m_e);
      m_ptr  = (m_win + 1) % NUM_REQ;
      m_busy = WORD_W + 2;
    end
  end

  // Monitor: follows each service from grant through the done pulse
  int                phase = 0;
  exp_t              cur;
  logic [WORD_W-1:0] seen;
  bit                hold_ok;
  always @(negedge clk) begin
    if (reset) begin
      phase = 0;
    end else if (phase == 0) begin
      if (done) check("spurious_done", 1, 0);
      if (gnt != '0) begin
        if (expq.size() == 0) begin
          check("unexpected_grant", int'(gnt), 0);
        end else begin
          cur = expq.pop_front();
          check("grant", int'(gnt), 1 << cur.id);
          check("det_reset_clear", int'(det_reset), 1);
          seen    = '0;
          hold_ok = 1'b1;
          phase   = 1;
        end
      end
    end else if (phase <= WORD_W) begin
      seen[WORD_W-phase] = det_x;
      if (int'(gnt) != (1 << cur.id) || det_reset || done) hold_ok = 1'b0;
      phase++;
    end else if (phase == WORD_W + 1) begin
      if (int'(gnt) != (1 << cur.id) || det_reset || done) hold_ok = 1'b0;
      check("det_x_stream", int'(seen), int'(cur.word));
      check("gnt_hold", int'(hold_ok), 1);
      phase++;
    end else begin
      check("done", int'(done), 1);
      check("done_id", int'(done_id), cur.id);
      check("hit_count", int'(hit_count), cur.hits);
`ifdef PDS_FIRST_HIT_EN
      check("first_pos", int'(first_pos), cur.first);
`endif
      check("gnt_released", int'(gnt), 0);
      phase = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (done) ok = 1'b1;
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic wait_gnt(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (gnt != '0) ok = 1'b1;
    end
    if (!ok) check("gnt_timeout", 0, 1);
  endtask

  int ids[$];
  int tdone[$];
  bit pend[NUM_REQ];
  bit saw;
  int ndone;
  int guard;

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    check("rst_gnt", int'(gnt), 0);
    check("rst_done", int'(done), 0);
    check("rst_det_reset", int'(det_reset), 1);
    check("rst_det_x", int'(det_x), 0);
    check("rst_done_id", int'(done_id), 0);
    check("rst_hit_count", int'(hit_count), 0);
`ifdef PDS_FIRST_HIT_EN
    check("rst_first_pos", int'(first_pos), WORD_W);
`endif
    reset = 1'b0;
    tick();
    check("idle_det_reset", int'(det_reset), 0);

    word_in[0 +: WORD_W] = 8'h52;
    req = 4'b0001;
    wait_done(30);
    req = '0;
    check("w52_done_id", int'(done_id), 0);
    check("w52_hits", int'(hit_count), 2);
`ifdef PDS_FIRST_HIT_EN
    check("w52_first_pos", int'(first_pos), 2);
`endif
    tick();

    word_in[WORD_W +: WORD_W] = 8'hFF;
    req = 4'b0010;
    wait_done(30);
    req = '0;
    check("wff_done_id", int'(done_id), 1);
    check("wff_hits", int'(hit_count), 0);
`ifdef PDS_FIRST_HIT_EN
    check("wff_first_pos", int'(first_pos), WORD_W);
`endif

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    word_in = 32'h3A_12_C4_55;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_done(30);
      ids.push_back(int'(done_id));
      tdone.push_back(cyc);
    end
    req = '0;
    for (int n = 0; n < 5; n++) check("fair_order", ids[n], n % NUM_REQ);
    for (int n = 1; n < 5; n++) check("grant_spacing", tdone[n] - tdone[n-1], WORD_W + 3);
    tick();

    word_in[2*WORD_W +: WORD_W] = 8'hA5;
    req = 4'b0100;
    wait_gnt(10);
    repeat (3) tick();
    req = '0;
    word_in[2*WORD_W +: WORD_W] = 8'h5A;
    wait_done(30);
    check("drop_done_id", int'(done_id), 2);
    check("drop_hits", int'(hit_count), 2);
    tick();

    word_in[0 +: WORD_W] = 8'h52;
    req = 4'b0001;
    wait_gnt(10);
    repeat (3) tick();
    reset = 1'b1;
    req = '0;
    #1;
    check("midrst_gnt", int'(gnt), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_det_reset", int'(det_reset), 1);
    check("midrst_done_id", int'(done_id), 0);
    check("midrst_hit_count", int'(hit_count), 0);
    tick();
    tick();
    reset = 1'b0;
    saw = 1'b0;
    repeat (15) begin
      tick();
      if (done || gnt != '0) saw = 1'b1;
    end
    check("quiet_after_reset", int'(saw), 0);

    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    ndone = 0;
    guard = 0;
    while (ndone < 1000 && guard < 40000) begin
      tick();
      guard++;
      if (done) begin
        pend[done_id] = 1'b0;
        req[done_id]  = 1'b0;
        ndone++;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          if ($urandom_range(15) == 0) req[i] = 1'b0;
          if ($urandom_range(3) == 0) word_in[i*WORD_W +: WORD_W] = WORD_W'($urandom);
        end else if (!pend[i] && $urandom_range(3) == 0) begin
          word_in[i*WORD_W +: WORD_W] = WORD_W'($urandom);
          req[i]  = 1'b1;
          pend[i] = 1'b1;
        end
      end
    end
    check("random_transfers", ndone, 1000);
    req = '0;
    repeat (15) tick();
    check("scoreboard_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
